vis_accumulator: RTL and testbench
==================================

VIS_ACCUMULATOR -- requirements
Module: vis_accumulator

Interface
REQ-001 SHALL have parameter PAIRS, default 540: visibility pairs per block, i.e. SRAM depth; legal range PAIRS >= 4.
REQ-002 SHALL have parameter WIDTH, default 36: accumulator and output width.
REQ-003 SHALL have parameter SBITS, default 6: unsigned partial-sum input width; SBITS < WIDTH.
REQ-004 SHALL have parameter CBITS, default 8: width of the pass-count input.
REQ-005 SHALL have parameter OBITS, default 4: output FIFO depth is 2**OBITS entries.
REQ-006 SHALL have port clock_i, input, 1: the single clock, with all logic on its rising edge.
REQ-007 SHALL have port reset_ni, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port clear_i, input, 1: synchronous restart.
REQ-009 SHALL have port count_i, input, CBITS: number of passes minus one.
REQ-010 SHALL have port valid_i, input, 1: the input beat is present.
REQ-011 SHALL have ports revis_i and imvis_i, input, SBITS each: real and imaginary partial sums.
REQ-012 SHALL have ports revis_o and imvis_o, output, WIDTH each: accumulated visibility.
REQ-013 SHALL have port valid_o, output, 1, plus port ready_i, input, 1: AXI4-Stream-style handshake.
REQ-014 SHALL have port last_o, output, 1: asserted on the beat for pair PAIRS-1.
REQ-015 SHALL have port overflow_o, output, 1: sticky flag for output FIFO overrun.

Function
REQ-016 SHALL keep an address counter (0..PAIRS-1) and a pass counter; each valid_i beat advances the address, wrapping PAIRS-1 -> 0; the pass counter increments on each address wrap.
REQ-017 SHALL hold all counters while valid_i is low, so idle gaps of any length do not change results.
REQ-018 SHALL sample count_i into an internal limit only when address=0 and pass=0 and a beat is accepted; the pass counter wraps to 0 after pass=limit.
REQ-019 SHALL use a 3-stage pipeline for a beat accepted in cycle N: SRAM read at N, add at N+1, write-back at N+2.
REQ-020 SHALL, on pass 0, add the input to zero rather than to SRAM contents, so no stale sums carry between blocks.
REQ-021 SHALL perform the addition by zero-extending the input to WIDTH and wrapping modulo 2**WIDTH (default build, see REQ-034).
REQ-022 SHALL, on pass=limit, push the sum into the output FIFO at N+2 instead of relying on write-back, tagging the entry last=1 for address PAIRS-1.
REQ-023 SHALL raise valid_o no earlier than N+3 for the beat accepted at N.
REQ-024 SHALL drive revis_o, imvis_o and last_o from the FIFO head.
REQ-025 SHALL pop the FIFO only when valid_o and ready_i are both high, and SHALL keep the outputs stable while valid_o=1 and ready_i=0.
REQ-026 SHALL handle a FIFO push and pop in the same cycle when full: both succeed and the count is unchanged.
REQ-027 SHALL, on a push to a full FIFO without a pop, drop the entry and set overflow_o=1, which remains set until reset or clear_i.
REQ-028 SHALL, when clear_i=1, zero the address and pass counters, cancel in-flight pipeline stages, flush the FIFO (valid_o=0 next cycle) and clear overflow_o.
REQ-029 SHALL give clear_i priority over a simultaneous valid_i, dropping that beat.
REQ-030 SHALL tolerate PAIRS >= 4 with no read-after-write forwarding: the same address is never read while a write to it is pending.

Reset
REQ-031 SHALL, while reset_ni=0, immediately force valid_o=0, last_o=0, revis_o=0, imvis_o=0 and overflow_o=0; zero the counters, limit and FIFO pointers; and cancel pipeline valids.
REQ-032 SHALL leave SRAM contents unreset; pass 0 overwrites them (REQ-020).
REQ-033 SHALL treat reset asserted mid-block like clear_i: the partial block is discarded and accumulation restarts at address 0, pass 0.

Configuration
REQ-034 SHALL, when macro ACCUM_SATURATE_EN is defined, clamp each add to 2**WIDTH-1 (real and imaginary independently); when undefined, the add wraps per REQ-021.

Verification
REQ-035 SHALL be checked with PAIRS=4, WIDTH=12, count_i=2, revis_i=1, imvis_i=2 for 12 beats -> 4 output beats of re=3, im=6, with last_o only on the 4th.
REQ-036 SHALL be checked with two back-to-back blocks (revis_i=1 then revis_i=2) -> second block outputs re=6, not 9, confirming the pass-0 clear.
REQ-037 SHALL be checked with the REQ-035 stimulus and valid_i toggling 1/0 -> outputs identical to REQ-035.
REQ-038 SHALL be checked with OBITS=2, ready_i=0 over two full blocks -> first 4 entries retained, overflow_o=1, and the head value unchanged.
REQ-039 SHALL be checked with WIDTH=8, count_i=31, revis_i=15 -> re=224 without ACCUM_SATURATE_EN and 255 with it.
REQ-040 SHALL be checked with clear_i pulsed after 6 beats, then 12 beats of REQ-035 stimulus -> the same 4 outputs as REQ-035 and overflow_o=0.

Source files
------------

// File: rtl/vis_accumulator.sv
// Multi-pass visibility accumulator: per-pair running sums held in block RAM, emitted through an output FIFO.
// Optional macro ACCUM_SATURATE_EN: clamp each add to 2**WIDTH-1 instead of wrapping.
module vis_accumulator #(
   parameter int PAIRS = 540,
   parameter int WIDTH = 36,
   parameter int SBITS = 6,
   parameter int CBITS = 8,
   parameter int OBITS = 4
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             clear_i,
   input  logic [CBITS-1:0] count_i,
   input  logic             valid_i,
   input  logic [SBITS-1:0] revis_i,
   input  logic [SBITS-1:0] imvis_i,
   output logic [WIDTH-1:0] revis_o,
   output logic [WIDTH-1:0] imvis_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic             overflow_o
);
   localparam int AW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int DEPTH = 2 ** OBITS;

   logic [AW-1:0]    addr_q, addr_d;
   logic [CBITS-1:0] pass_q, pass_d, limit_q, limit_d, eff_limit;
   logic             beat, first_beat, addr_end, final_pass;

   logic             s1_valid_q, s1_valid_d, s1_zero_q, s1_zero_d;
   logic             s1_final_q, s1_final_d, s1_last_q, s1_last_d;
   logic [AW-1:0]    s1_addr_q, s1_addr_d;
   logic [SBITS-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;

   logic             s2_valid_q, s2_valid_d, s2_final_q, s2_final_d, s2_last_q, s2_last_d;
   logic [AW-1:0]    s2_addr_q, s2_addr_d;
   logic [WIDTH-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;

   logic [2*WIDTH-1:0] mem [PAIRS];
   logic [2*WIDTH-1:0] mem_rd_q;
   logic               mem_we, push;
   logic [WIDTH-1:0]   base_re, base_im, sum_re, sum_im;

   logic [WIDTH-1:0] fifo_re [DEPTH];
   logic [WIDTH-1:0] fifo_im [DEPTH];
   logic             fifo_last [DEPTH];
   logic [OBITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
   logic             full, empty, pop, push_ok, overflow_q, overflow_d;

   // The first beat of a block must use count_i directly, since limit_q only loads on that edge.
   always_comb begin
      beat       = valid_i & ~clear_i;
      first_beat = (addr_q == '0) && (pass_q == '0);
      eff_limit  = first_beat ? count_i : limit_q;
      addr_end   = (addr_q == AW'(PAIRS - 1));
      final_pass = (pass_q == eff_limit);
      addr_d     = addr_q;
      pass_d     = pass_q;
      limit_d    = limit_q;
      if (clear_i) begin
         addr_d = '0;
         pass_d = '0;
      end else if (valid_i) begin
         if (first_beat) limit_d = count_i;
         addr_d = addr_end ? '0 : addr_q + AW'(1);
         if (addr_end) pass_d = final_pass ? '0 : pass_q + CBITS'(1);
      end
   end

   always_comb begin
      s1_valid_d = beat;
      s1_addr_d  = addr_q;
      s1_zero_d  = (pass_q == '0);
      s1_final_d = final_pass;
      s1_last_d  = final_pass & addr_end;
      s1_re_d    = revis_i;
      s1_im_d    = imvis_i;
   end

   always_ff @(posedge clock_i) begin
      if (mem_we) mem[s2_addr_q] <= {s2_re_q, s2_im_q};
      mem_rd_q <= mem[addr_q];
   end

   // Pass 0 starts from zero so stale sums from an earlier block never leak in.
   always_comb begin
      base_re = s1_zero_q ? '0 : mem_rd_q[2*WIDTH-1:WIDTH];
      base_im = s1_zero_q ? '0 : mem_rd_q[WIDTH-1:0];
   end

`ifdef ACCUM_SATURATE_EN
   logic [WIDTH:0] sum_re_w, sum_im_w;
   always_comb begin
      sum_re_w = {1'b0, base_re} + {{(WIDTH+1-SBITS){1'b0}}, s1_re_q};
      sum_im_w = {1'b0, base_im} + {{(WIDTH+1-SBITS){1'b0}}, s1_im_q};
      sum_re   = sum_re_w[WIDTH] ? '1 : sum_re_w[WIDTH-1:0];
      sum_im   = sum_im_w[WIDTH] ? '1 : sum_im_w[WIDTH-1:0];
   end
`else
   always_comb begin
      sum_re = base_re + {{(WIDTH-SBITS){1'b0}}, s1_re_q};
      sum_im = base_im + {{(WIDTH-SBITS){1'b0}}, s1_im_q};
   end
`endif

   always_comb begin
      s2_valid_d = s1_valid_q & ~clear_i;
      s2_addr_d  = s1_addr_q;
      s2_final_d = s1_final_q;
      s2_last_d  = s1_last_q;
      s2_re_d    = sum_re;
      s2_im_d    = sum_im;
      mem_we     = s2_valid_q & ~s2_final_q & ~clear_i;
      push       = s2_valid_q &  s2_final_q & ~clear_i;
   end

   // A push into a full FIFO only lands when the head leaves in the same cycle.
   always_comb begin
      fill       = wr_ptr_q - rd_ptr_q;
      full       = (fill == (OBITS+1)'(DEPTH));
      empty      = (fill == '0);
      pop        = ~empty & ready_i;
      push_ok    = push & (~full | pop);
      wr_ptr_d   = wr_ptr_q + {{OBITS{1'b0}}, push_ok};
      rd_ptr_d   = rd_ptr_q + {{OBITS{1'b0}}, pop};
      overflow_d = overflow_q | (push & full & ~pop);
      if (clear_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (push_ok) begin
         fifo_re[wr_ptr_q[OBITS-1:0]]   <= s2_re_q;
         fifo_im[wr_ptr_q[OBITS-1:0]]   <= s2_im_q;
         fifo_last[wr_ptr_q[OBITS-1:0]] <= s2_last_q;
      end
   end

   always_comb begin
      valid_o    = ~empty;
      revis_o    = empty ? '0 : fifo_re[rd_ptr_q[OBITS-1:0]];
      imvis_o    = empty ? '0 : fifo_im[rd_ptr_q[OBITS-1:0]];
      last_o     = empty ? 1'b0 : fifo_last[rd_ptr_q[OBITS-1:0]];
      overflow_o = overflow_q;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         addr_q     <= '0;
         pass_q     <= '0;
         limit_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_zero_q  <= 1'b0;
         s1_final_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_re_q    <= '0;
         s1_im_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_final_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_re_q    <= '0;
         s2_im_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         pass_q     <= pass_d;
         limit_q    <= limit_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_zero_q  <= s1_zero_d;
         s1_final_q <= s1_final_d;
         s1_last_q  <= s1_last_d;
         s1_re_q    <= s1_re_d;
         s1_im_q    <= s1_im_d;
         s2_valid_q <= s2_valid_d;
         s2_addr_q  <= s2_addr_d;
         s2_final_q <= s2_final_d;
         s2_last_q  <= s2_last_d;
         s2_re_q    <= s2_re_d;
         s2_im_q    <= s2_im_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_vis_accumulator.sv
// Bench for vis_accumulator: two instances (WIDTH 12 and WIDTH 8) share one directed stimulus stream;
// a block-level model queues the expected outputs and one process compares them every cycle.
module tb_vis_accumulator;
   logic        clock = 1'b0;
   logic        reset_n, clear, valid, ready;
   logic [7:0]  count;
   logic [5:0]  re_in, im_in;
   logic [11:0] a_re, a_im;
   logic        a_valid, a_last, a_ovf;
   logic [7:0]  w_re, w_im;
   logic        w_valid, w_last, w_ovf;

   always #5 clock = ~clock;

   vis_accumulator #(.PAIRS(4), .WIDTH(12), .SBITS(6), .CBITS(8), .OBITS(2)) dut_a (
      .clock_i(clock), .reset_ni(reset_n), .clear_i(clear), .count_i(count), .valid_i(valid),
      .revis_i(re_in), .imvis_i(im_in), .revis_o(a_re), .imvis_o(a_im), .valid_o(a_valid),
      .ready_i(ready), .last_o(a_last), .overflow_o(a_ovf));

   vis_accumulator #(.PAIRS(4), .WIDTH(8), .SBITS(6), .CBITS(8), .OBITS(2)) dut_w (
      .clock_i(clock), .reset_ni(reset_n), .clear_i(clear), .count_i(count), .valid_i(valid),
      .revis_i(re_in), .imvis_i(im_in), .revis_o(w_re), .imvis_o(w_im), .valid_o(w_valid),
      .ready_i(ready), .last_o(w_last), .overflow_o(w_ovf));

   typedef struct { int re; int im; bit last; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   last_re[2], last_im[2];
   bit   last_last[2];
   bit   stall_prev[2];

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every add is non-negative, so clamping each add equals clamping the block total.
   function automatic int model_val(int total, int width);
`ifdef ACCUM_SATURATE_EN
      return (total > (1 << width) - 1) ? (1 << width) - 1 : total;
`else
      return total % (1 << width);
`endif
   endfunction

   always @(negedge clock) begin
      int   ore, oim;
      bit   ov, ol, have;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            ore = int'(a_re); oim = int'(a_im); ov = a_valid; ol = a_last;
            have = (q0.size() != 0);
            if (have) e = q0[0];
         end else begin
            ore = int'(w_re); oim = int'(w_im); ov = w_valid; ol = w_last;
            have = (q1.size() != 0);
            if (have) e = q1[0];
         end
         if (!reset_n) begin
            stall_prev[d] = 1'b0;
         end else begin
            if (stall_prev[d]) chk($sformatf("hold_valid_%0d", d), longint'(ov), 1);
            if (ov) begin
               if (!have) begin
                  chk($sformatf("unexpected_beat_%0d", d), 1, 0);
               end else begin
                  chk($sformatf("re_%0d", d), ore, e.re);
                  chk($sformatf("im_%0d", d), oim, e.im);
                  chk($sformatf("last_%0d", d), longint'(ol), longint'(e.last));
                  if (ready) begin
                     $display("beat dut%0d re=%0d im=%0d last=%0d", d, ore, oim, ol);
                     last_re[d] = ore; last_im[d] = oim; last_last[d] = ol;
                     if (d == 0) void'(q0.pop_front());
                     else        void'(q1.pop_front());
                  end
               end
            end
            stall_prev[d] = ov && !ready;
         end
      end
   end

   task automatic drive(bit v, int re, int im);
      @(posedge clock);
      #1;
      valid = v;
      re_in = 6'(re);
      im_in = 6'(im);
   endtask

   // One block of (cnt+1) passes over the 4 pairs; pair a carries re_b + re_s*a.
   task automatic send_block(int cnt, int re_b, int re_s, int im_b, bit gap);
      exp_t e;
      count = 8'(cnt);
      for (int p = 0; p <= cnt; p++) begin
         for (int a = 0; a < 4; a++) begin
            if (p == cnt) begin
               e.last = (a == 3);
               e.re = model_val((cnt + 1) * (re_b + re_s * a), 12);
               e.im = model_val((cnt + 1) * im_b, 12);
               q0.push_back(e);
               e.re = model_val((cnt + 1) * (re_b + re_s * a), 8);
               e.im = model_val((cnt + 1) * im_b, 8);
               q1.push_back(e);
            end
            drive(1'b1, re_b + re_s * a, im_b);
            if (gap) drive(1'b0, 0, 0);
         end
      end
   endtask

   task automatic idle();
      drive(1'b0, 0, 0);
   endtask

   task automatic pulse_clear(bit with_valid);
      @(posedge clock);
      #1;
      clear = 1'b1;
      valid = with_valid;
      re_in = 6'd20;
      @(posedge clock);
      #1;
      clear = 1'b0;
      valid = 1'b0;
   endtask

   task automatic wait_drain(string name);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_drain_left"}, q0.size() + q1.size(), 0);
      repeat (4) @(negedge clock);
      chk({name, "_idle_valid_a"}, longint'(a_valid), 0);
      chk({name, "_idle_valid_w"}, longint'(w_valid), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; valid = 1'b0; ready = 1'b1;
      count = '0; re_in = '0; im_in = '0;
      @(posedge clock);
      #1;
      chk("reset_valid_a", longint'(a_valid), 0);
      chk("reset_re_a", longint'(a_re), 0);
      chk("reset_last_a", longint'(a_last), 0);
      chk("reset_ovf_a", longint'(a_ovf), 0);
      chk("reset_valid_w", longint'(w_valid), 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Basic three-pass block.
      send_block(2, 1, 0, 2, 1'b0);
      idle();
      wait_drain("basic");
      chk("basic_lit_re", last_re[0], 3);
      chk("basic_lit_im", last_im[0], 6);
      chk("basic_lit_last", longint'(last_last[0]), 1);
      chk("basic_lit_re_w", last_re[1], 3);

      // Back-to-back blocks: the second must restart from zero.
      send_block(2, 1, 0, 2, 1'b0);
      send_block(2, 2, 0, 2, 1'b0);
      idle();
      wait_drain("b2b");
      chk("b2b_lit_re", last_re[0], 6);

      // Idle gaps between every beat.
      send_block(2, 1, 0, 2, 1'b1);
      idle();
      wait_drain("gaps");
      chk("gaps_lit_re", last_re[0], 3);

      // Per-pair values and a single-pass block.
      send_block(1, 5, 3, 7, 1'b0);
      send_block(0, 9, 1, 4, 1'b0);
      idle();
      wait_drain("pairs");
      chk("pairs_lit_re", last_re[0], 12);

      // 32 passes of 15: wraps or clamps in the 8-bit instance.
      send_block(31, 15, 0, 1, 1'b0);
      idle();
      wait_drain("wide");
      chk("wide_lit_re_a", last_re[0], 480);
`ifdef ACCUM_SATURATE_EN
      chk("wide_lit_re_w", last_re[1], 255);
`else
      chk("wide_lit_re_w", last_re[1], 224);
`endif
      chk("wide_lit_im_w", last_im[1], 32);

      // Overrun with ready low over two blocks: only the first four entries survive.
      @(posedge clock);
      #1;
      ready = 1'b0;
      send_block(2, 1, 0, 2, 1'b0);
      send_block(2, 2, 0, 4, 1'b0);
      idle();
      repeat (6) @(negedge clock);
      while (q0.size() > 4) void'(q0.pop_back());
      while (q1.size() > 4) void'(q1.pop_back());
      chk("ovf_flag_a", longint'(a_ovf), 1);
      chk("ovf_flag_w", longint'(w_ovf), 1);
      chk("ovf_head_re", longint'(a_re), 3);
      repeat (5) @(negedge clock);
      chk("ovf_head_re_later", longint'(a_re), 3);
      @(posedge clock);
      #1;
      ready = 1'b1;
      wait_drain("ovf");
      chk("ovf_sticky_a", longint'(a_ovf), 1);
      pulse_clear(1'b0);
      @(negedge clock);
      chk("ovf_cleared_a", longint'(a_ovf), 0);
      chk("ovf_cleared_w", longint'(w_ovf), 0);

      // Partial block, clear with a coincident beat, then a full block.
      count = 8'd2;
      for (int i = 0; i < 6; i++) drive(1'b1, 1, 2);
      pulse_clear(1'b1);
      send_block(2, 1, 0, 2, 1'b0);
      idle();
      wait_drain("clear");
      chk("clear_lit_re", last_re[0], 3);
      chk("clear_ovf_a", longint'(a_ovf), 0);

      // Asynchronous reset mid-block with data waiting in the FIFO.
      @(posedge clock);
      #1;
      ready = 1'b0;
      send_block(0, 9, 0, 1, 1'b0);
      idle();
      repeat (4) @(negedge clock);
      chk("pre_reset_valid_a", longint'(a_valid), 1);
      drive(1'b1, 1, 2);
      drive(1'b1, 1, 2);
      #2;
      reset_n = 1'b0;
      valid = 1'b0;
      #1;
      chk("async_reset_valid_a", longint'(a_valid), 0);
      chk("async_reset_re_a", longint'(a_re), 0);
      chk("async_reset_last_a", longint'(a_last), 0);
      chk("async_reset_valid_w", longint'(w_valid), 0);
      q0.delete();
      q1.delete();
      ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      send_block(2, 1, 0, 2, 1'b0);
      idle();
      wait_drain("post_reset");
      chk("post_reset_lit_re", last_re[0], 3);
      chk("post_reset_lit_im", last_im[0], 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
